// File: rtl/security_pkg.sv
// Shared types and default constants for the entry-lockout security path.
package security_pkg;

  typedef enum logic [2:0] {
    ARMED    = 3'd0,
    COUNT    = 3'd1,
    RELEASE  = 3'd2,
    UNLOCKED = 3'd3,
    ALARM    = 3'd4
  } state_e;

  localparam int MAX_TRIES_D    = 3;
  localparam int LOCK_SECS_D    = 3;
  localparam int MAX_LOCKOUTS_D = 2;

endpackage

// File: rtl/lockout_sequencer_if.sv
// Keypad-event inputs and status outputs of the lockout sequencer.
interface lockout_sequencer_if #(
  parameter int CW = 4
);
  import security_pkg::*;

  logic          tick;
  logic          pass_ok;
  logic          pass_fail;
  logic          relock;
  logic          admin_clr;
  logic [1:0]    tries_left;
  logic [CW-1:0] count;
  logic          entry_en;
  logic          unlocked;
  logic          alarm;
  logic          rst_all;

  modport master (
    output tick, pass_ok, pass_fail, relock, admin_clr,
    input  tries_left, count, entry_en, unlocked, alarm, rst_all
  );

  modport slave (
    input  tick, pass_ok, pass_fail, relock, admin_clr,
    output tries_left, count, entry_en, unlocked, alarm, rst_all
  );

endinterface

// File: rtl/lockout_sequencer_timer.sv
// Loadable tick-enabled down-counter; done fires on a tick while already at zero.
module lockout_timer
  import security_pkg::*;
#(
  parameter int CW       = 4,
  parameter int LOAD_VAL = LOCK_SECS_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  // Next count: load wins, otherwise decrement on enabled ticks until zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CW'(LOAD_VAL);
    end else if (en && tick && (count_q != {CW{1'b0}})) begin
      count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CW'(LOAD_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = en && tick && (count_q == {CW{1'b0}});

endmodule

// File: rtl/lockout_sequencer.sv
// Failed-attempt counter and lockout/alarm sequencer between the password comparator and the countdown display.
module lockout_sequencer
  import security_pkg::*;
#(
  parameter int MAX_TRIES    = MAX_TRIES_D,
  parameter int LOCK_SECS    = LOCK_SECS_D,
  parameter int MAX_LOCKOUTS = MAX_LOCKOUTS_D,
  parameter int CW           = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lockout_sequencer_if.slave   bus
);

  localparam int LW = $clog2(MAX_LOCKOUTS + 1);

  state_e        state_d, state_q;
  logic [1:0]    tries_d, tries_q;
  logic [LW-1:0] lockouts_d, lockouts_q;
  logic [LW-1:0] lockouts_inc_s;
  logic          entry_en_d, entry_en_q;
  logic          unlocked_d, unlocked_q;
  logic          alarm_d, alarm_q;
  logic          rst_all_d, rst_all_q;
  logic          timer_load_s;
  logic          timer_en_s;
  logic          timer_done_s;
  logic [CW-1:0] timer_count_s;

  // Entry into COUNT happens from ARMED, where the timer is disabled, so a coincident tick is ignored.
  assign timer_en_s   = (state_q == COUNT);
  assign timer_load_s = (state_q != COUNT) || (state_d != COUNT);

  lockout_timer #(
    .CW       (CW),
    .LOAD_VAL (LOCK_SECS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load_s),
    .en    (timer_en_s),
    .tick  (bus.tick),
    .count (timer_count_s),
    .done  (timer_done_s)
  );

  assign lockouts_inc_s = lockouts_q + {{(LW-1){1'b0}}, 1'b1};

  // Next-state, attempt and lockout counter logic.
  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    lockouts_d = lockouts_q;
    case (state_q)
      ARMED: begin
        if (bus.pass_fail) begin
          if (tries_q > 2'd1) begin
            tries_d = tries_q - 2'd1;
          end else begin
            tries_d    = 2'd0;
            lockouts_d = lockouts_inc_s;
            if (lockouts_inc_s == LW'(MAX_LOCKOUTS)) begin
              state_d = ALARM;
            end else begin
              state_d = COUNT;
            end
          end
        end else if (bus.pass_ok) begin
          state_d    = UNLOCKED;
          tries_d    = 2'(MAX_TRIES);
          lockouts_d = {LW{1'b0}};
        end else begin
          state_d = ARMED;
        end
      end
      COUNT: begin
        if (bus.admin_clr) begin
          state_d    = RELEASE;
          tries_d    = 2'(MAX_TRIES);
          lockouts_d = {LW{1'b0}};
        end else if (timer_done_s) begin
          state_d = RELEASE;
          tries_d = 2'(MAX_TRIES);
        end else begin
          state_d = COUNT;
        end
      end
      RELEASE: begin
        state_d = ARMED;
        tries_d = 2'(MAX_TRIES);
      end
      UNLOCKED: begin
        if (bus.relock) begin
          state_d = ARMED;
        end else begin
          state_d = UNLOCKED;
        end
      end
      ALARM: begin
        if (bus.admin_clr) begin
          state_d    = RELEASE;
          tries_d    = 2'(MAX_TRIES);
          lockouts_d = {LW{1'b0}};
        end else begin
          state_d = ALARM;
        end
      end
      default: begin
        state_d    = ARMED;
        tries_d    = 2'(MAX_TRIES);
        lockouts_d = {LW{1'b0}};
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    entry_en_d = (state_d == ARMED);
    unlocked_d = (state_d == UNLOCKED);
    alarm_d    = (state_d == ALARM);
    rst_all_d  = (state_d == RELEASE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARMED;
      tries_q    <= 2'(MAX_TRIES);
      lockouts_q <= {LW{1'b0}};
      entry_en_q <= 1'b1;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      rst_all_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      lockouts_q <= lockouts_d;
      entry_en_q <= entry_en_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
      rst_all_q  <= rst_all_d;
    end
  end

  assign bus.tries_left = tries_q;
  assign bus.count      = timer_count_s;
  assign bus.entry_en   = entry_en_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.alarm      = alarm_q;
  assign bus.rst_all    = rst_all_q;

endmodule
